fetch_sequencer: RTL and testbench

Drives the instruction-memory read address and turns the synchronous-BRAM read data into an in-order, tagged instruction stream for decode. It owns the PC, the start/boot sequence, stall backpressure, branch redirects and the BRAM read-latency bookkeeping. It sits between the instruction BRAM (address out, douta in) and the decode stage.

---
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control in, BRAM address/data, decode-side stream out.
// slave = fetch_sequencer side, master = environment (BRAM + decode + control).
interface fetch_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int INST_W = 16
);
  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [INST_W-1:0] inst_in;
  logic [ADDR_W-1:0] address;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              running;

  modport slave (
    input  start,
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  inst_in,
    output address,
    output if_inst,
    output if_pc,
    output if_valid,
    output running
  );

  modport master (
    output start,
    output stall,
    output branch_taken,
    output branch_target,
    output inst_in,
    input  address,
    input  if_inst,
    input  if_pc,
    input  if_valid,
    input  running
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives BRAM addra, tags reads through the
// BRAM latency and presents an in-order {if_inst, if_pc, if_valid} stream.
// Ports: clk, rst (sync, active high), bus (fetch_sequencer_if.slave):
//   start, stall, branch_taken, branch_target, inst_in (BRAM douta) in;
//   address (BRAM addra), if_inst, if_pc, if_valid, running out.
// Optional: define HALT_DETECT_EN to stop fetching on HALT_OPCODE.
module fetch_sequencer #(
  parameter int                ADDR_W      = 12,
  parameter int                INST_W      = 16,
  parameter int                MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = 12'h000,
  parameter logic [ADDR_W-1:0] START_ADDR  = 12'h004,
  parameter logic [INST_W-1:0] HALT_OPCODE = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef HALT_DETECT_EN
  localparam logic [1:0] S_HALT = 2'd2;
`endif

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] pc;
  } tag_t;

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  tag_t              tag_q [MEM_LATENCY];
  logic              if_v_q;
  logic [ADDR_W-1:0] if_pc_q;
  logic [INST_W-1:0] if_inst_q;

  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              old_v;
  logic [ADDR_W-1:0] old_pc;
  logic              halt_hit;
  logic              issue;

  // Branches only redirect a running fetch; start always (re)starts.
  always_comb begin
    redir    = 1'b0;
    redir_pc = START_ADDR;
    if (bus.branch_taken && state_q == S_RUN) begin
      redir    = 1'b1;
      redir_pc = bus.branch_target;
    end else if (bus.start) begin
      redir    = 1'b1;
    end
  end

  // Oldest in-flight read: the first PC not yet handed to decode.
  always_comb begin
    old_v  = 1'b0;
    old_pc = addr_q;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (tag_q[i].v) begin
        old_v  = 1'b1;
        old_pc = tag_q[i].pc;
      end
    end
  end

`ifdef HALT_DETECT_EN
  assign halt_hit = tag_q[MEM_LATENCY-1].v &&
                    (bus.inst_in == HALT_OPCODE);
`else
  logic unused_halt;
  assign unused_halt = ^HALT_OPCODE;
  assign halt_hit    = 1'b0;
`endif

  assign issue = (state_q == S_RUN) && !halt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= RESET_ADDR;
      if_v_q    <= 1'b0;
      if_pc_q   <= '0;
      if_inst_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++)
        tag_q[i] <= '0;
    end else if (redir) begin
      state_q <= S_RUN;
      addr_q  <= redir_pc;
      if_v_q  <= 1'b0;
      for (int i = 0; i < MEM_LATENCY; i++)
        tag_q[i] <= '0;
    end else if (bus.stall) begin
      // Drop in-flight reads and rewind so they
      // are refetched once decode accepts again.
      for (int i = 0; i < MEM_LATENCY; i++)
        tag_q[i] <= '0;
      if (old_v)
        addr_q <= old_pc;
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--)
        tag_q[i] <= tag_q[i-1];
      tag_q[0] <= '{v: issue, pc: addr_q};
      if (issue)
        addr_q <= addr_q + ADDR_W'(1);
      if_v_q <= tag_q[MEM_LATENCY-1].v;
      if (tag_q[MEM_LATENCY-1].v) begin
        if_pc_q   <= tag_q[MEM_LATENCY-1].pc;
        if_inst_q <= bus.inst_in;
      end
`ifdef HALT_DETECT_EN
      if (halt_hit) begin
        state_q <= S_HALT;
        for (int i = 0; i < MEM_LATENCY; i++)
          tag_q[i] <= '0;
      end
`endif
    end
  end

  assign bus.address  = addr_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_v_q;
  assign bus.running  = (state_q == S_RUN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: MEM_LATENCY 1 and 2 instances side by side,
// each fed by its own BRAM model; accepted stream checked per scenario.
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start;
  logic          br;
  logic [AW-1:0] tgt;
  logic          st [2];
  logic [IW-1:0] mem [4096];

  fetch_sequencer_if #(.ADDR_W(AW), .INST_W(IW)) b1 ();
  fetch_sequencer_if #(.ADDR_W(AW), .INST_W(IW)) b2 ();

  assign b1.start         = start;
  assign b1.stall         = st[0];
  assign b1.branch_taken  = br;
  assign b1.branch_target = tgt;
  assign b2.start         = start;
  assign b2.stall         = st[1];
  assign b2.branch_taken  = br;
  assign b2.branch_target = tgt;

  // Synchronous BRAMs: douta follows addra by 1 or 2 clocks.
  logic [IW-1:0] rd2;
  always @(posedge clk) begin
    b1.inst_in <= mem[b1.address];
    rd2        <= mem[b2.address];
    b2.inst_in <= rd2;
  end

  fetch_sequencer #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  fetch_sequencer #(.MEM_LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave));

  logic [AW-1:0] o_addr [2];
  logic [AW-1:0] o_pc   [2];
  logic [IW-1:0] o_inst [2];
  logic          o_v    [2];
  logic          o_run  [2];
  assign o_addr[0] = b1.address;
  assign o_addr[1] = b2.address;
  assign o_pc[0]   = b1.if_pc;
  assign o_pc[1]   = b2.if_pc;
  assign o_inst[0] = b1.if_inst;
  assign o_inst[1] = b2.if_inst;
  assign o_v[0]    = b1.if_valid;
  assign o_v[1]    = b2.if_valid;
  assign o_run[0]  = b1.running;
  assign o_run[1]  = b2.running;

  // Accepted instructions, tagged with the edge that consumes them.
  typedef struct {
    int            d;
    int            e;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } acc_t;
  acc_t accq [$];

  always @(negedge clk)
    if (!rst)
      for (int d = 0; d < 2; d++)
        if (o_v[d] && !st[d])
          accq.push_back('{d, cyc + 1, o_pc[d], o_inst[d]});

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [IW-1:0] rnd_word();
    logic [IW-1:0] w;
    w = IW'($urandom);
    if (w == 16'hFFFF) w = 16'h0000;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; br = 1'b0; tgt = '0;
    st[0] = 1'b0; st[1] = 1'b0;
    tick(2);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (o_addr[d] !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_addr dut%0d got %h want 000", d, o_addr[d]);
      end
      n_chk++;
      if (o_v[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid dut%0d got %b want 0", d, o_v[d]);
      end
      n_chk++;
      if (o_run[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_run dut%0d got %b want 0", d, o_run[d]);
      end
    end
    rst = 1'b0;
    tick(3);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (o_addr[d] !== 12'h000 || o_v[d] !== 1'b0 || o_run[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold dut%0d got addr=%h v=%b run=%b want 000/0/0",
                 d, o_addr[d], o_v[d], o_run[d]);
      end
    end
    n_chk++;
    if (accq.size() != 0) begin
      n_fail++;
      $display("FAIL idle_accepts got %0d want 0", accq.size());
    end
  endtask

  task automatic test_start_latency();
    acc_t q [$];
    logic [IW-1:0] want [4];
    int n0;
    want = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    accq.delete();
    n0 = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (o_addr[d] !== 12'h004 || o_run[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL start_addr dut%0d got addr=%h run=%b want 004/1",
                 d, o_addr[d], o_run[d]);
      end
    end
    tick(10);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > n0) q.push_back(accq[i]);
      n_chk++;
      if (q.size() < 4) begin
        n_fail++;
        $display("FAIL start_count dut%0d got %0d want >=4", d, q.size());
      end else begin
        // decode takes the first instruction at edge N+MEM_LATENCY+2
        n_chk++;
        if (q[0].e !== n0 + d + 3) begin
          n_fail++;
          $display("FAIL start_latency dut%0d got edge %0d want %0d",
                   d, q[0].e - n0, d + 3);
        end
        for (int i = 0; i < 4; i++) begin
          n_chk++;
          if (q[i].pc !== AW'(4 + i) || q[i].inst !== want[i] ||
              q[i].e !== q[0].e + i) begin
            n_fail++;
            $display("FAIL start_stream dut%0d #%0d got pc=%h inst=%h e=%0d want %h/%h/%0d",
                     d, i, q[i].pc, q[i].inst, q[i].e, AW'(4 + i), want[i], q[0].e + i);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    acc_t q [$];
    int k;
    int rel;
    for (int d = 0; d < 2; d++) begin
      accq.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!(o_v[d] && o_pc[d] == 12'h005) && k < 20) begin
        tick();
        k++;
      end
      n_chk++;
      if (k >= 20) begin
        n_fail++;
        $display("FAIL stall_reach dut%0d got timeout want pc 005", d);
      end
      st[d] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        n_chk++;
        if (o_v[d] !== 1'b1 || o_pc[d] !== 12'h005 || o_inst[d] !== 16'h2222) begin
          n_fail++;
          $display("FAIL stall_hold dut%0d c%0d got v=%b pc=%h inst=%h want 1/005/2222",
                   d, j, o_v[d], o_pc[d], o_inst[d]);
        end
      end
      st[d] = 1'b0;
      rel = cyc + 1;
      tick(8);
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e >= rel) q.push_back(accq[i]);
      n_chk++;
      if (q.size() < 3 ||
          q[0].pc !== 12'h005 || q[0].e !== rel ||
          q[1].pc !== 12'h006 || q[1].inst !== 16'h3333 ||
          q[1].e !== rel + d + 2 ||
          q[2].pc !== 12'h007 || q[2].inst !== 16'h4444) begin
        n_fail++;
        $display("FAIL stall_release dut%0d got n=%0d pcs=%h,%h,%h gap=%0d want 005,006,007 gap %0d",
                 d, q.size(), q.size() > 0 ? q[0].pc : 12'hxxx,
                 q.size() > 1 ? q[1].pc : 12'hxxx, q.size() > 2 ? q[2].pc : 12'hxxx,
                 q.size() > 1 ? q[1].e - rel : -1, d + 2);
      end
    end
  endtask

  task automatic test_branch_stall();
    acc_t q [$];
    int b;
    b = cyc + 1;
    br = 1'b1; tgt = 12'h100;
    st[0] = 1'b1; st[1] = 1'b1;
    tick();
    br = 1'b0; st[0] = 1'b0; st[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (o_v[d] !== 1'b0 || o_addr[d] !== 12'h100) begin
        n_fail++;
        $display("FAIL branch_flush dut%0d got v=%b addr=%h want 0/100",
                 d, o_v[d], o_addr[d]);
      end
    end
    tick(8);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > b) q.push_back(accq[i]);
      n_chk++;
      if (q.size() < 1 || q[0].pc !== 12'h100 || q[0].inst !== 16'hABCD ||
          q[0].e !== b + d + 3) begin
        n_fail++;
        $display("FAIL branch_target dut%0d got n=%0d pc=%h inst=%h want 100/abcd at +%0d",
                 d, q.size(), q.size() > 0 ? q[0].pc : 12'hxxx,
                 q.size() > 0 ? q[0].inst : 16'hxxxx, d + 3);
      end
    end
  endtask

  task automatic test_wrap();
    acc_t q [$];
    logic [AW-1:0] wp;
    int b;
    b = cyc + 1;
    br = 1'b1; tgt = 12'hFFE;
    tick();
    br = 1'b0;
    tick(10);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > b) q.push_back(accq[i]);
      n_chk++;
      if (q.size() < 4) begin
        n_fail++;
        $display("FAIL wrap_count dut%0d got %0d want >=4", d, q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          wp = AW'((12'hFFE + i) % 4096);
          n_chk++;
          if (q[i].pc !== wp || q[i].inst !== mem[wp]) begin
            n_fail++;
            $display("FAIL wrap_stream dut%0d #%0d got %h/%h want %h/%h",
                     d, i, q[i].pc, q[i].inst, wp, mem[wp]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (o_v[d] !== 1'b0 || o_addr[d] !== 12'h000 || o_run[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst dut%0d got v=%b addr=%h run=%b want 0/000/0",
                 d, o_v[d], o_addr[d], o_run[d]);
      end
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (o_v[d] !== 1'b0 || o_run[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale dut%0d got v=%b run=%b want 0/0",
                 d, o_v[d], o_run[d]);
      end
    end
  endtask

  // Reference: decode must see consecutive PCs from the latest redirect,
  // each carrying mem[pc], never earlier than latency+2 edges after it.
  task automatic test_random();
    int            red_e  [$];
    logic [AW-1:0] red_pc [$];
    logic [AW-1:0] exp_pc;
    int ri;
    int n;
    accq.delete();
    red_e.push_back(cyc + 1);
    red_pc.push_back(12'h004);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) begin
      st[0] = ($urandom % 100) < 30;
      st[1] = ($urandom % 100) < 30;
      br = 1'b0;
      if (($urandom % 100) < 6) begin
        br  = 1'b1;
        tgt = AW'($urandom);
        red_e.push_back(cyc + 1);
        red_pc.push_back(tgt);
      end
      tick();
    end
    br = 1'b0; st[0] = 1'b0; st[1] = 1'b0;
    tick(6);
    for (int d = 0; d < 2; d++) begin
      ri = 0; n = 0; exp_pc = '0;
      foreach (accq[i]) begin
        if (accq[i].d != d) continue;
        while (ri < red_e.size() && red_e[ri] < accq[i].e) begin
          exp_pc = red_pc[ri];
          ri++;
        end
        if (ri == 0) continue;
        n_chk++;
        if (accq[i].pc !== exp_pc || accq[i].inst !== mem[exp_pc] ||
            accq[i].e < red_e[ri-1] + d + 3) begin
          n_fail++;
          $display("FAIL rand_stream dut%0d e=%0d got %h/%h want %h/%h (redirect e=%0d)",
                   d, accq[i].e, accq[i].pc, accq[i].inst, exp_pc, mem[exp_pc],
                   red_e[ri-1]);
        end
        exp_pc = exp_pc + 12'd1;
        n++;
      end
      n_chk++;
      if (n < 40) begin
        n_fail++;
        $display("FAIL rand_progress dut%0d got %0d accepts want >=40", d, n);
      end
    end
  endtask

`ifdef HALT_DETECT_EN
  task automatic test_halt();
    acc_t q [$];
    logic [AW-1:0] a [2];
    int n0;
    int n2;
    mem[6] = 16'hFFFF;
    accq.delete();
    n0 = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(12);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > n0) q.push_back(accq[i]);
      n_chk++;
      if (q.size() != 3 || q[0].pc !== 12'h004 || q[1].pc !== 12'h005 ||
          q[2].pc !== 12'h006 || q[2].inst !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL halt_stream dut%0d got n=%0d want pcs 004,005,006(ffff)",
                 d, q.size());
      end
      n_chk++;
      if (o_v[d] !== 1'b0 || o_run[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_state dut%0d got v=%b run=%b want 0/0", d, o_v[d], o_run[d]);
      end
      a[d] = o_addr[d];
    end
    tick(3);
    br = 1'b1; tgt = 12'h200;
    tick();
    br = 1'b0;
    tick(6);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > n0) q.push_back(accq[i]);
      n_chk++;
      if (q.size() != 3 || o_addr[d] !== a[d] || o_run[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_frozen dut%0d got n=%0d addr=%h run=%b want 3/%h/0",
                 d, q.size(), o_addr[d], o_run[d], a[d]);
      end
    end
    n2 = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(8);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > n2) q.push_back(accq[i]);
      n_chk++;
      if (q.size() < 1 || q[0].pc !== 12'h004 || q[0].inst !== 16'h1111) begin
        n_fail++;
        $display("FAIL halt_restart dut%0d got n=%0d pc=%h want 004/1111",
                 d, q.size(), q.size() > 0 ? q[0].pc : 12'hxxx);
      end
    end
    mem[6] = 16'h3333;
  endtask
`else
  task automatic test_halt_opcode_plain();
    acc_t q [$];
    int n0;
    mem[6] = 16'hFFFF;
    accq.delete();
    n0 = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(12);
    for (int d = 0; d < 2; d++) begin
      q.delete();
      foreach (accq[i]) if (accq[i].d == d && accq[i].e > n0) q.push_back(accq[i]);
      n_chk++;
      if (q.size() < 6 || q[2].pc !== 12'h006 || q[2].inst !== 16'hFFFF ||
          q[5].pc !== 12'h009 || o_run[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL ffff_plain dut%0d got n=%0d run=%b want >=6 pcs 004.. and run=1",
                 d, q.size(), o_run[d]);
      end
    end
    mem[6] = 16'h3333;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = rnd_word();
    mem[4] = 16'h1111;
    mem[5] = 16'h2222;
    mem[6] = 16'h3333;
    mem[7] = 16'h4444;
    mem[12'h100] = 16'hABCD;
    test_reset();
    test_start_latency();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_reset_midstream();
    test_random();
`ifdef HALT_DETECT_EN
    test_halt();
`else
    test_halt_opcode_plain();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
